// File: rtl/stream_mux_pkg.sv
// Shared types for the round-robin stream multiplexer.
package stream_mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter (rotate, priority-encode, rotate back).
// Priority starts at ptr and wraps N-1 -> 0; grant is one-hot, grant_idx its encoded index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [N-1:0]  rot_s;
  logic [IW-1:0] pos_s;
  logic          found_s;

  function automatic logic [IW-1:0] wrap_idx(input int a);
    return IW'(a % N);
  endfunction

  // Rotate requests so ptr sits at bit 0, pick the lowest set bit, then map back.
  always_comb begin
    rot_s   = '0;
    pos_s   = '0;
    found_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      rot_s[i] = req[wrap_idx(i + int'(ptr))];
    end
    for (int i = 0; i < N; i++) begin
      if (rot_s[i] && !found_s) begin
        found_s = 1'b1;
        pos_s   = IW'(i);
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      grant_idx = wrap_idx(int'(pos_s) + int'(ptr));
      grant     = N'(1) << grant_idx;
    end else begin
      grant_idx = '0;
      grant     = '0;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel round-robin valid/ready stream mux with a one-beat registered output.
// Define STREAM_MUX_RR_PKT_LOCK_EN to hold the grant on a channel until its last beat.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic [N_CH-1:0][W-1:0] in_data,
  input  logic [N_CH-1:0]        in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_data,
  output logic                   out_last,
  output logic [SEL_W-1:0]       out_sel
);

  typedef logic [SEL_W-1:0] ch_idx_t;

  ch_idx_t         ptr_r;
  ch_idx_t         ptr_nx_s;
  ch_idx_t         arb_idx_s;
  ch_idx_t         gnt_idx_s;
  logic [N_CH-1:0] arb_gnt_s;
  logic [N_CH-1:0] gnt_vec_s;
  logic            load_en_s;
  logic            xfer_s;
  logic            ptr_adv_s;

  rr_arbiter #(.N(N_CH), .IW(SEL_W)) u_arb (
    .req       (in_valid),
    .ptr       (ptr_r),
    .grant     (arb_gnt_s),
    .grant_idx (arb_idx_s)
  );

`ifdef STREAM_MUX_RR_PKT_LOCK_EN
  lock_state_t state_r;
  lock_state_t state_nx_s;
  ch_idx_t     lock_ch_r;
  ch_idx_t     lock_ch_nx_s;
  logic        gnt_last_s;

  // While locked the grant is pinned to lock_ch, whether or not it is valid.
  always_comb begin
    gnt_vec_s = arb_gnt_s;
    gnt_idx_s = arb_idx_s;
    if (state_r == LOCKED) begin
      gnt_vec_s = N_CH'(1) << lock_ch_r;
      gnt_idx_s = lock_ch_r;
    end else begin
      gnt_vec_s = arb_gnt_s;
      gnt_idx_s = arb_idx_s;
    end
  end

  assign gnt_last_s = in_last[gnt_idx_s];
  assign ptr_adv_s  = xfer_s && gnt_last_s;

  // Lock state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      lock_ch_r <= '0;
    end else begin
      state_r   <= state_nx_s;
      lock_ch_r <= lock_ch_nx_s;
    end
  end

  // Lock next-state: enter on a non-last beat, leave on the locked channel's last beat.
  always_comb begin
    state_nx_s   = state_r;
    lock_ch_nx_s = lock_ch_r;
    case (state_r)
      IDLE: begin
        if (xfer_s && !gnt_last_s) begin
          state_nx_s   = LOCKED;
          lock_ch_nx_s = gnt_idx_s;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOCKED: begin
        if (xfer_s && gnt_last_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = LOCKED;
        end
      end
      default: begin
        state_nx_s   = IDLE;
        lock_ch_nx_s = '0;
      end
    endcase
  end
`else
  // Per-beat arbitration: the arbiter result is used directly.
  always_comb begin
    gnt_vec_s = arb_gnt_s;
    gnt_idx_s = arb_idx_s;
  end

  assign ptr_adv_s = xfer_s;
`endif

  assign load_en_s = !out_valid || out_ready;
  assign in_ready  = (load_en_s && !rst) ? gnt_vec_s : '0;
  assign xfer_s    = |(in_valid & in_ready);
  assign ptr_nx_s  = (gnt_idx_s == ch_idx_t'(N_CH - 1)) ? '0 : gnt_idx_s + ch_idx_t'(1);

  // Output beat register: reload on transfer, clear valid on drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (xfer_s) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gnt_idx_s];
      out_last  <= in_last[gnt_idx_s];
      out_sel   <= gnt_idx_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // Round-robin pointer: next search starts after the channel that was served.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (ptr_adv_s) begin
      ptr_r <= ptr_nx_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard testbench for stream_mux_rr (N_CH=4, W=8); expectations follow STREAM_MUX_RR_PKT_LOCK_EN.
module tb_stream_mux_rr;

  logic             clk;
  logic             rst;
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [3:0][7:0]  in_data;
  logic [3:0]       in_last;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic [1:0]       out_sel;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] sel;
  } beat_t;

  beat_t exp_q[$];
  int    tests;
  int    fails;

  logic [3:0] lk_valid [5];
  logic [7:0] lk_d1    [5];
  logic       lk_l1    [5];
  logic [3:0] lk_rdy_gap;

  stream_mux_rr #(.N_CH(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic l, input logic [1:0] s);
    beat_t b;
    b.data = d;
    b.last = l;
    b.sel  = s;
    exp_q.push_back(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst      = 1'b1;
    in_valid = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  // Monitor: every beat the sink accepts is popped from the scoreboard and compared.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got data %h sel %0d expected no beat", out_data, out_sel);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(out_data), 32'(e.data));
          check("beat_sel",  32'(out_sel),  32'(e.sel));
          check("beat_last", 32'(out_last), 32'(e.last));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    in_valid  = 4'b1111;
    in_data   = '0;
    in_last   = 4'b0000;
    out_ready = 1'b0;

    // Reset state; requests during reset must not be acknowledged.
    tick();
    tick();
    check("rst_in_ready",  32'(in_ready),  32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data",  32'(out_data),  32'h0);
    check("rst_out_last",  32'(out_last),  32'h0);
    check("rst_out_sel",   32'(out_sel),   32'h0);
    in_valid = 4'b0000;
    rst      = 1'b0;
    tick();

    // Single channel, one-cycle latency.
    in_valid   = 4'b0100;
    in_data[2] = 8'h5a;
    in_last    = 4'b0100;
    out_ready  = 1'b1;
    push_exp(8'h5a, 1'b1, 2'd2);
    tick();
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_data",  32'(out_data),  32'h5a);
    check("single_sel",   32'(out_sel),   32'h2);
    check("single_last",  32'(out_last),  32'h1);
    in_valid = 4'b0000;
    tick();
    tick();

    // Round-robin fairness across four always-valid channels.
    reset_dut();
    in_data  = {8'h0d, 8'h0c, 8'h0b, 8'h0a};
    in_last  = 4'b1111;
    in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      push_exp(8'(8'h0a + (i % 4)), 1'b1, 2'(i % 4));
    end
    repeat (8) tick();
    in_valid = 4'b0000;
    tick();
    tick();

    // Backpressure hold, then release with back-to-back reload.
    reset_dut();
    out_ready  = 1'b0;
    in_data[0] = 8'h11;
    in_data[1] = 8'h22;
    in_last    = 4'b0011;
    in_valid   = 4'b0011;
    push_exp(8'h11, 1'b1, 2'd0);
    push_exp(8'h22, 1'b1, 2'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("bp_in_ready",  32'(in_ready),  32'h0);
      check("bp_out_valid", 32'(out_valid), 32'h1);
      check("bp_out_data",  32'(out_data),  32'h11);
      check("bp_out_sel",   32'(out_sel),   32'h0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'h2);
    tick();
    check("nobubble_valid", 32'(out_valid), 32'h1);
    check("nobubble_data",  32'(out_data),  32'h22);
    in_valid = 4'b0000;
    tick();
    tick();

    // Packet of three beats on channel 1 against a continuously valid channel 0.
    reset_dut();
`ifdef STREAM_MUX_RR_PKT_LOCK_EN
    lk_valid   = '{4'b0010, 4'b0001, 4'b0011, 4'b0011, 4'b0001};
    lk_d1      = '{8'h81, 8'h82, 8'h82, 8'h83, 8'h83};
    lk_l1      = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    lk_rdy_gap = 4'b0010;
    push_exp(8'h81, 1'b0, 2'd1);
    push_exp(8'h82, 1'b0, 2'd1);
    push_exp(8'h83, 1'b1, 2'd1);
    push_exp(8'h70, 1'b1, 2'd0);
`else
    lk_valid   = '{4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
    lk_d1      = '{8'h81, 8'h82, 8'h82, 8'h83, 8'h83};
    lk_l1      = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    lk_rdy_gap = 4'b0001;
    push_exp(8'h81, 1'b0, 2'd1);
    push_exp(8'h70, 1'b1, 2'd0);
    push_exp(8'h82, 1'b0, 2'd1);
    push_exp(8'h70, 1'b1, 2'd0);
    push_exp(8'h83, 1'b1, 2'd1);
`endif
    in_data[0] = 8'h70;
    in_last[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid   = lk_valid[c];
      in_data[1] = lk_d1[c];
      in_last[1] = lk_l1[c];
      if (c == 1) begin
        #1;
        check("lock_in_ready", 32'(in_ready), 32'(lk_rdy_gap));
      end
      tick();
    end
    in_valid = 4'b0000;
    tick();
    tick();

    // X data passes through unchanged.
    reset_dut();
    in_data  = {8'hxx, 8'h03, 8'h0a, 8'h07};
    in_last  = 4'b1111;
    in_valid = 4'b1111;
    push_exp(8'h07, 1'b1, 2'd0);
    push_exp(8'h0a, 1'b1, 2'd1);
    push_exp(8'h03, 1'b1, 2'd2);
    push_exp(8'hxx, 1'b1, 2'd3);
    repeat (4) tick();
    in_valid = 4'b0000;
    tick();
    tick();

    // Reset in the middle of a channel 2 packet.
    reset_dut();
    in_data    = '0;
    in_data[2] = 8'h21;
    in_last    = 4'b0000;
    in_valid   = 4'b0100;
    tick();
    check("mid_pre_sel",  32'(out_sel),  32'h2);
    check("mid_pre_data", 32'(out_data), 32'h21);
    rst        = 1'b1;
    in_valid   = 4'b0101;
    in_data[2] = 8'h22;
    in_data[0] = 8'h31;
    in_last[0] = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    check("mid_out_valid", 32'(out_valid), 32'h0);
    check("mid_out_data",  32'(out_data),  32'h0);
    check("mid_out_last",  32'(out_last),  32'h0);
    check("mid_out_sel",   32'(out_sel),   32'h0);
    rst = 1'b0;
    push_exp(8'h31, 1'b1, 2'd0);
    tick();
    in_valid = 4'b0000;
    tick();
    tick();

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      tick();
    end
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
